// File: rtl/mult_sched.sv
// rtl/mult_sched.sv - round-robin shared shift-add N x N multiplier for two requesters
// Optional build macro: MULT_SCHED_EARLY_EXIT_EN (finish once the remaining multiplier bits are zero)
module mult_sched #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0,
  input  logic [N-1:0]   a0,
  input  logic [N-1:0]   b0,
  input  logic           req1,
  input  logic [N-1:0]   a1,
  input  logic [N-1:0]   b1,
  output logic           gnt0,
  output logic           gnt1,
  output logic           busy,
  output logic           done,
  output logic           done_id,
  output logic [2*N-1:0] result
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t         state, state_n;
  logic [2*N-1:0] acc, acc_n;
  logic [2*N-1:0] mcand, mcand_n;
  logic [N-1:0]   mplier, mplier_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic           owner, owner_n;
  logic           last, last_n;
  logic           gnt0_n, gnt1_n, busy_n, done_n, done_id_n;
  logic [2*N-1:0] result_n;
  logic [2*N-1:0] acc_sum;
  logic           sel;
  logic           early;
  logic           finish;

  assign acc_sum = acc + (mplier[0] ? mcand : '0);

`ifdef MULT_SCHED_EARLY_EXIT_EN
  assign early = ((mplier >> 1) == '0);
`else
  assign early = 1'b0;
`endif

  assign finish = (cnt == CW'(N - 1)) || early;

  // On a tie the port that was not served last wins; a lone request always wins.
  assign sel = (req0 && req1) ? ~last : req1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      owner   <= 1'b0;
      last    <= 1'b1;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      done_id <= 1'b0;
      result  <= '0;
    end else begin
      state   <= state_n;
      acc     <= acc_n;
      mcand   <= mcand_n;
      mplier  <= mplier_n;
      cnt     <= cnt_n;
      owner   <= owner_n;
      last    <= last_n;
      gnt0    <= gnt0_n;
      gnt1    <= gnt1_n;
      busy    <= busy_n;
      done    <= done_n;
      done_id <= done_id_n;
      result  <= result_n;
    end
  end

  always_comb begin
    state_n   = state;
    acc_n     = acc;
    mcand_n   = mcand;
    mplier_n  = mplier;
    cnt_n     = cnt;
    owner_n   = owner;
    last_n    = last;
    gnt0_n    = 1'b0;
    gnt1_n    = 1'b0;
    busy_n    = busy;
    done_n    = 1'b0;
    done_id_n = done_id;
    result_n  = result;

    case (state)
      S_IDLE: begin
        if (req0 || req1) begin
          mcand_n  = {{N{1'b0}}, (sel ? a1 : a0)};
          mplier_n = sel ? b1 : b0;
          acc_n    = '0;
          cnt_n    = '0;
          owner_n  = sel;
          last_n   = sel;
          gnt0_n   = ~sel;
          gnt1_n   = sel;
          busy_n   = 1'b1;
          state_n  = S_RUN;
        end
      end

      S_RUN: begin
        acc_n    = acc_sum;
        mcand_n  = mcand << 1;
        mplier_n = mplier >> 1;
        cnt_n    = cnt + CW'(1);
        if (finish) begin
          result_n  = acc_sum;
          done_id_n = owner;
          done_n    = 1'b1;
          state_n   = S_DONE;
        end
      end

      S_DONE: begin
        busy_n  = 1'b0;
        state_n = S_IDLE;
      end

      default: begin
        busy_n  = 1'b0;
        state_n = S_IDLE;
      end
    endcase
  end

endmodule

// File: doc/mult_sched.md
Name: mult_sched

Overview:
- Sequential multiply controller/arbiter for the mini-computer datapath.
- Shares one shift-add multiplier datapath between two requesters (port 0: ALU, port 1: address/index unit) using round-robin arbitration.
- Sequences the unsigned N×N multiply over multiple cycles, then returns a 2N-bit product tagged with the requester ID.

Parameters:
N, 8, operand width in bits; product width is 2N; N >= 2

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous active-high reset
req0  input  1  requester 0 multiply request; held high until gnt0 is seen
a0  input  N  requester 0 multiplicand
b0  input  N  requester 0 multiplier
req1  input  1  requester 1 multiply request; held high until gnt1 is seen
a1  input  N  requester 1 multiplicand
b1  input  N  requester 1 multiplier
gnt0  output  1  one-cycle pulse: requester 0 operands accepted
gnt1  output  1  one-cycle pulse: requester 1 operands accepted
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse: result valid
done_id  output  1  requester owning the current result (0/1)
result  output  2N  unsigned product; held until the next done

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset (async, at any time, including mid-operation):
  - gnt0 = gnt1 = busy = done = done_id = 0; result = 0.
  - state = IDLE; internal accumulator, shift registers and counter cleared.
  - Round-robin pointer last = 1, so port 0 wins the first tie.
  - An in-flight job is dropped with no done; the requester must re-request.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE:
  - Sample req0/req1 at each edge. No request: stay in IDLE.
  - One request: grant it. Both: grant the port != last.
  - On the grant edge:
    - Latch mcand = a_x zero-extended to 2N bits, mplier = b_x.
    - acc = 0, cnt = 0, owner = x, last = x.
    - gnt_x = 1 for the next cycle only; state -> RUN.
- RUN, one iteration per cycle:
  - If mplier[0] = 1: acc <= acc + mcand (2N-bit add, no overflow possible).
  - mcand <= mcand << 1; mplier <= mplier >> 1; cnt <= cnt + 1.
  - When cnt = N-1, at that edge: result <= final acc, done_id <= owner, done <= 1; state -> DONE.
  - req0/req1 are ignored in RUN and DONE. A requester seeing gnt high drops or changes req in the same cycle.
- DONE: done high for exactly this cycle. Next edge: done = 0, state -> IDLE.
- Latency:
  - Accept edge E0; done is high in the cycle following edge E_N (N+1 edges later).
  - Minimum spacing between accept edges is N+2 cycles.
- Fairness: a port holding req continuously is served at least every second job.
- Boundaries:
  - a = 0 or b = 0: result 0, same latency.
  - a = b = 2^N-1: result (2^N-1)^2, no wrap.
  - A new request arriving in DONE waits for IDLE.
  - busy = 1 throughout RUN and DONE.

Optional Feature:
MULT_SCHED_EARLY_EXIT_EN
- Defined: in RUN, if the shifted multiplier (mplier >> 1) is zero, finish at that edge (same actions as cnt = N-1).
  - Latency becomes max(1, index of highest set bit of b + 1) RUN cycles.
  - b = 0 gives done in the cycle after E1.
- Undefined: fixed N RUN cycles for every operand.
- Results are identical in both builds.

Test Plan:
- Reset: rst pulsed asynchronously between edges -> all outputs 0 immediately, state IDLE.
- Single job, N=8: req0, a0=13, b0=11 -> gnt0 pulse the cycle after E0; done=1, done_id=0, result=143 in the cycle after E8; busy low after.
- Tie: req0 (a0=255, b0=255) and req1 (a1=7, b1=6) both held -> results 65025 (id 0) then 42 (id 1). Keep both asserted for 4 jobs -> id order 0,1,0,1.
- Zero operand: a1=0, b1=200 -> result 0 with N-cycle latency. b0=0 -> result 0; with MULT_SCHED_EARLY_EXIT_EN, done in the cycle after E1.
- Reset mid-RUN: assert rst at cnt=3 of a job -> no done. Next req1, a1=9, b1=9 -> result 81, id 1 (rr pointer reset).
- Early exit (macro on): a0=100, b0=3 -> result 300 with done in the cycle after E2. Macro off -> same result in the cycle after E8.
